mux_pack: RTL

- Return path of the decryption datapath: collects 8-bit plaintext bytes from the three decryption channels and packs them into 32-bit words for the master side.
- One channel is selected per word. Bytes are packed MSB-first, the same byte order the splitting demux uses.
- Emits one 32-bit word with a single-cycle valid strobe per four accepted bytes. A flush request emits a partial word.

---
 rtl/mux_pack.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_pack.sv
// rtl/mux_pack.sv - packs channel bytes MSB-first into master-side words
module mux_pack #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [1:0]            select,
    input  logic [SYS_DWIDTH-1:0] data0_i,
    input  logic                  valid0_i,
    input  logic [SYS_DWIDTH-1:0] data1_i,
    input  logic                  valid1_i,
    input  logic [SYS_DWIDTH-1:0] data2_i,
    input  logic                  valid2_i,
    input  logic                  flush_i,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [2:0]            bytes_o,
    output logic                  drop_o
);

    localparam int NBYTES = MST_DWIDTH / SYS_DWIDTH;

    logic [1:0]            cnt_q, cnt_d;
    logic [MST_DWIDTH-1:0] pack_q, pack_d;
    logic [1:0]            lock_q, lock_d;
    logic [MST_DWIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [2:0]            bytes_q, bytes_d;
    logic                  drop_q, drop_d;

    logic [1:0]            act_ch;
    logic [2:0]            act_mask;
    logic [2:0]            vin;
    logic                  acc;
    logic [SYS_DWIDTH-1:0] byte_in;
    logic [MST_DWIDTH-1:0] pack_w;
    logic [2:0]            cnt_w;
    logic                  emit;

    // Select active channel, classify incoming bytes and decide on emission
    always_comb begin
        act_ch   = (cnt_q == 2'd0) ? select : lock_q;
        vin      = {valid2_i, valid1_i, valid0_i};
        act_mask = 3'b000;
        byte_in  = '0;
        case (act_ch)
            2'd0: begin act_mask = 3'b001; byte_in = data0_i; end
            2'd1: begin act_mask = 3'b010; byte_in = data1_i; end
            2'd2: begin act_mask = 3'b100; byte_in = data2_i; end
            default: begin act_mask = 3'b000; byte_in = '0; end
        endcase
        acc    = |(vin & act_mask);
        drop_d = |(vin & ~act_mask);

        // Insert the accepted byte at the slot addressed by the byte counter
        pack_w = pack_q;
        if (acc) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (cnt_q == i[1:0]) begin
                    pack_w[MST_DWIDTH-1-SYS_DWIDTH*i -: SYS_DWIDTH] = byte_in;
                end
            end
        end
        cnt_w = {1'b0, cnt_q} + {2'b00, acc};

        // Full word, or flush with at least one byte pending (including this cycle's)
        emit = (acc && (cnt_q == 2'd3)) || (flush_i && (cnt_w != 3'd0));

        cnt_d   = cnt_w[1:0];
        pack_d  = pack_w;
        lock_d  = lock_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        valid_d = 1'b0;
        if (acc && (cnt_q == 2'd0)) begin
            lock_d = select;
        end
        if (emit) begin
            data_d  = pack_w;
            bytes_d = cnt_w;
            valid_d = 1'b1;
            cnt_d   = 2'd0;
            pack_d  = '0;
            lock_d  = 2'd3;
        end
    end

    // State and output registers; reset discards any partial word
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            pack_q  <= '0;
            lock_q  <= 2'd3;
            data_q  <= '0;
            valid_q <= 1'b0;
            bytes_q <= 3'd0;
            drop_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            bytes_q <= bytes_d;
            drop_q  <= drop_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign bytes_o = bytes_q;
    assign drop_o  = drop_q;

endmodule
